// File: rtl/stage_channel_sequencer.sv
// stage_channel_sequencer
//   Launches up to NUM_CH channel engines from a single stage_ready pulse and
//   joins their done pulses into one stage_done. Channels either start
//   together (SEQUENTIAL=0) or one at a time in ascending index order when
//   they share a memory port (SEQUENTIAL=1). A watchdog ends a run that stops
//   making progress. All outputs are registered.
//
// Ports
//   clk            stage clock
//   rst            asynchronous active-low reset
//   stage_ready    one-cycle start pulse
//   channel_mask   enabled channels, sampled when stage_ready is accepted
//   channel_ready  one-cycle launch pulse per channel
//   channel_done   one-cycle completion pulse per channel
//   stage_done     one-cycle pulse when the run ends (complete or watchdog)
//   stage_busy     high while a run is in progress
//   stage_timeout  one-cycle pulse alongside stage_done when the watchdog ended the run
//   done_status    channels completed in the last run
//   overrun        sticky flag: stage_ready arrived while busy
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for stage_ready; an empty mask finishes immediately
// RUN   | channels launched, collecting done pulses, watchdog counting
module stage_channel_sequencer #(
  parameter int NUM_CH         = 2,
  parameter int SEQUENTIAL     = 0,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TO_W           = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stage_ready,
  input  logic [NUM_CH-1:0] channel_mask,
  output logic [NUM_CH-1:0] channel_ready,
  input  logic [NUM_CH-1:0] channel_done,
  output logic              stage_done,
  output logic              stage_busy,
  output logic              stage_timeout,
  output logic [NUM_CH-1:0] done_status,
  output logic              overrun
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam bit            WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t            state;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] launched;
  logic [TO_W-1:0]   wd_cnt;

  logic [NUM_CH-1:0] accepted;
  logic [NUM_CH-1:0] status_next;
  logic [NUM_CH-1:0] next_launch;
  logic [NUM_CH-1:0] first_launch;
  logic              wd_fire;

  function automatic logic [NUM_CH-1:0] lowest_bit(input logic [NUM_CH-1:0] v);
    logic [NUM_CH-1:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  always_comb begin
    // launched is updated on the same edge that raises channel_ready, so a
    // done arriving in the launch-pulse cycle is already eligible.
    accepted     = channel_done & launched & ~done_status;
    status_next  = done_status | accepted;
    next_launch  = lowest_bit(pending & ~launched);
    first_launch = (SEQUENTIAL != 0) ? lowest_bit(channel_mask) : channel_mask;
    // Any accepted done restarts the watchdog, so it only fires on a quiet cycle.
    wd_fire      = WD_EN && (wd_cnt == WD_LAST) && (accepted == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      pending       <= '0;
      launched      <= '0;
      wd_cnt        <= '0;
      channel_ready <= '0;
      stage_done    <= 1'b0;
      stage_busy    <= 1'b0;
      stage_timeout <= 1'b0;
      done_status   <= '0;
      overrun       <= 1'b0;
    end else begin
      channel_ready <= '0;
      stage_done    <= 1'b0;
      stage_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (stage_ready) begin
            done_status <= '0;
            wd_cnt      <= '0;
            if (channel_mask == '0) begin
              stage_done <= 1'b1;
            end else begin
              pending       <= channel_mask;
              launched      <= first_launch;
              channel_ready <= first_launch;
              stage_busy    <= 1'b1;
              state         <= RUN;
            end
          end
        end
        RUN: begin
          if (stage_ready) overrun <= 1'b1;
          done_status <= status_next;
          if (status_next == pending) begin
            stage_done <= 1'b1;
            stage_busy <= 1'b0;
            launched   <= '0;
            wd_cnt     <= '0;
            state      <= IDLE;
          end else if (wd_fire) begin
            // Unlaunched channels are abandoned; done_status keeps the partial set.
            stage_done    <= 1'b1;
            stage_timeout <= 1'b1;
            stage_busy    <= 1'b0;
            launched      <= '0;
            wd_cnt        <= '0;
            state         <= IDLE;
          end else if (accepted != '0) begin
            wd_cnt <= '0;
            if (SEQUENTIAL != 0) begin
              channel_ready <= next_launch;
              launched      <= launched | next_launch;
            end
          end else begin
            wd_cnt <= wd_cnt + TO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_channel_sequencer.sv
// Directed bench for stage_channel_sequencer: a 2-channel parallel instance
// with a 16-cycle watchdog and a 4-channel sequential instance.
module tb_stage_channel_sequencer;

  logic       clk;
  logic       rst;

  logic       p_ready;
  logic [1:0] p_mask;
  logic [1:0] p_chr;
  logic [1:0] p_done;
  logic       p_sdone;
  logic       p_busy;
  logic       p_tout;
  logic [1:0] p_status;
  logic       p_ovr;

  logic       s_ready;
  logic [3:0] s_mask;
  logic [3:0] s_chr;
  logic [3:0] s_done;
  logic       s_sdone;
  logic       s_busy;
  logic       s_tout;
  logic [3:0] s_status;
  logic       s_ovr;
  logic [3:0] s_seen;

  int errors = 0;
  int checks = 0;

  stage_channel_sequencer #(
    .NUM_CH(2), .SEQUENTIAL(0), .TIMEOUT_CYCLES(16), .TO_W(8)
  ) dut_par (
    .clk(clk), .rst(rst), .stage_ready(p_ready), .channel_mask(p_mask),
    .channel_ready(p_chr), .channel_done(p_done), .stage_done(p_sdone),
    .stage_busy(p_busy), .stage_timeout(p_tout), .done_status(p_status),
    .overrun(p_ovr)
  );

  stage_channel_sequencer #(
    .NUM_CH(4), .SEQUENTIAL(1), .TIMEOUT_CYCLES(64), .TO_W(8)
  ) dut_seq (
    .clk(clk), .rst(rst), .stage_ready(s_ready), .channel_mask(s_mask),
    .channel_ready(s_chr), .channel_done(s_done), .stage_done(s_sdone),
    .stage_busy(s_busy), .stage_timeout(s_tout), .done_status(s_status),
    .overrun(s_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL time_limit observed=expired expected=finished");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge; pulse inputs drop here.
  task automatic tick();
    @(posedge clk);
    #1;
    p_ready = 1'b0;
    p_done  = '0;
    s_ready = 1'b0;
    s_done  = '0;
    s_seen  = s_seen | s_chr;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b0;
    p_ready = 1'b0; p_mask = '0; p_done = '0;
    s_ready = 1'b0; s_mask = '0; s_done = '0;
    s_seen = '0;
    ticks(2);
    chk("rst_p_chr", p_chr, 0);
    chk("rst_p_sdone", p_sdone, 0);
    chk("rst_p_busy", p_busy, 0);
    chk("rst_p_tout", p_tout, 0);
    chk("rst_p_status", p_status, 0);
    chk("rst_p_ovr", p_ovr, 0);
    chk("rst_s_chr", s_chr, 0);
    chk("rst_s_busy", s_busy, 0);
    rst = 1'b1;
    tick();

    // Parallel, mask 11: launch both, join at t10
    p_ready = 1'b1; p_mask = 2'b11;
    tick();                                   // t1
    chk("par_t1_chr", p_chr, 2'b11);
    chk("par_t1_busy", p_busy, 1);
    tick();                                   // t2
    chk("par_t2_chr_pulse", p_chr, 0);
    ticks(3);                                 // t5
    p_done = 2'b01;
    tick();                                   // t6
    chk("par_t6_status", p_status, 2'b01);
    chk("par_t6_sdone", p_sdone, 0);
    ticks(3);                                 // t9
    chk("par_t9_sdone", p_sdone, 0);
    p_done = 2'b10;
    tick();                                   // t10
    chk("par_t10_sdone", p_sdone, 1);
    chk("par_t10_status", p_status, 2'b11);
    chk("par_t10_busy", p_busy, 0);
    chk("par_t10_tout", p_tout, 0);
    tick();                                   // t11
    chk("par_t11_sdone", p_sdone, 0);

    // Mono frame: spurious done[1] ignored
    p_ready = 1'b1; p_mask = 2'b01;
    tick();                                   // t1
    chk("mono_t1_chr", p_chr, 2'b01);
    ticks(2);                                 // t3
    p_done = 2'b10;
    tick();                                   // t4
    chk("mono_t4_sdone", p_sdone, 0);
    chk("mono_t4_status", p_status, 0);
    p_done = 2'b01;
    tick();                                   // t5
    chk("mono_t5_sdone", p_sdone, 1);
    chk("mono_t5_status", p_status, 2'b01);
    chk("mono_t5_busy", p_busy, 0);

    // Empty mask, accepted in the stage_done cycle
    p_ready = 1'b1; p_mask = 2'b00;
    tick();
    chk("empty_sdone", p_sdone, 1);
    chk("empty_status", p_status, 0);
    chk("empty_chr", p_chr, 0);
    chk("empty_busy", p_busy, 0);

    // Accept while stage_done high; overrun; duplicate done
    p_ready = 1'b1; p_mask = 2'b11;
    tick();                                   // u1
    chk("ovr_u1_chr", p_chr, 2'b11);
    chk("ovr_u1_ovr", p_ovr, 0);
    p_ready = 1'b1; p_mask = 2'b01;
    tick();                                   // u2
    chk("ovr_u2_ovr", p_ovr, 1);
    chk("ovr_u2_chr", p_chr, 0);
    chk("ovr_u2_busy", p_busy, 1);
    p_done = 2'b01;
    tick();                                   // u3
    p_done = 2'b01;
    tick();                                   // u4
    chk("dup_u4_sdone", p_sdone, 0);
    chk("dup_u4_status", p_status, 2'b01);
    p_done = 2'b10;
    tick();                                   // u5
    chk("ovr_u5_sdone", p_sdone, 1);
    chk("ovr_u5_status", p_status, 2'b11);

    // Simultaneous dones in the launch cycle
    p_ready = 1'b1; p_mask = 2'b11;
    tick();                                   // v1
    chk("sim_v1_chr", p_chr, 2'b11);
    p_done = 2'b11;
    tick();                                   // v2
    chk("sim_v2_sdone", p_sdone, 1);
    chk("sim_v2_status", p_status, 2'b11);
    chk("sim_v2_tout", p_tout, 0);
    chk("sim_v2_ovr", p_ovr, 1);

    // Watchdog: only done[0] at w3, timeout at w20
    p_ready = 1'b1; p_mask = 2'b11;
    ticks(3);                                 // w3
    p_done = 2'b01;
    ticks(16);                                // w19
    chk("wd_w19_sdone", p_sdone, 0);
    chk("wd_w19_busy", p_busy, 1);
    tick();                                   // w20
    chk("wd_w20_sdone", p_sdone, 1);
    chk("wd_w20_tout", p_tout, 1);
    chk("wd_w20_status", p_status, 2'b01);
    chk("wd_w20_busy", p_busy, 0);
    tick();                                   // w21
    chk("wd_w21_tout", p_tout, 0);
    p_done = 2'b10;
    tick();                                   // w22
    chk("wd_w22_sdone", p_sdone, 0);
    chk("wd_w22_status", p_status, 2'b01);

    // Sequential, mask 1010
    s_seen = '0;
    s_ready = 1'b1; s_mask = 4'b1010;
    tick();                                   // t1
    chk("seq_t1_chr", s_chr, 4'b0010);
    chk("seq_t1_busy", s_busy, 1);
    tick();                                   // t2
    chk("seq_t2_chr", s_chr, 0);
    tick();                                   // t3
    s_done = 4'b1000;
    ticks(3);                                 // t6
    s_done = 4'b0010;
    tick();                                   // t7
    chk("seq_t7_chr", s_chr, 4'b1000);
    chk("seq_t7_status", s_status, 4'b0010);
    chk("seq_t7_sdone", s_sdone, 0);
    ticks(5);                                 // t12
    s_done = 4'b1000;
    tick();                                   // t13
    chk("seq_t13_sdone", s_sdone, 1);
    chk("seq_t13_status", s_status, 4'b1010);
    chk("seq_t13_chr", s_chr, 0);
    chk("seq_t13_tout", s_tout, 0);
    chk("seq_launched_set", s_seen, 4'b1010);

    // Asynchronous reset mid-run
    p_ready = 1'b1; p_mask = 2'b11;
    tick();                                   // x1
    chk("arst_x1_chr", p_chr, 2'b11);
    p_ready = 1'b1;
    tick();                                   // x2
    chk("arst_x2_busy", p_busy, 1);
    chk("arst_x2_ovr", p_ovr, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_busy", p_busy, 0);
    chk("arst_ovr", p_ovr, 0);
    chk("arst_status", p_status, 0);
    chk("arst_sdone", p_sdone, 0);
    tick();
    rst = 1'b1;
    p_done = 2'b11;
    tick();
    chk("arst_post_sdone", p_sdone, 0);
    chk("arst_post_busy", p_busy, 0);
    p_ready = 1'b1; p_mask = 2'b10;
    tick();
    chk("arst_new_chr", p_chr, 2'b10);
    p_done = 2'b10;
    tick();
    chk("arst_new_sdone", p_sdone, 1);
    chk("arst_new_status", p_status, 2'b10);
    chk("arst_new_ovr", p_ovr, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stage_channel_sequencer.md
Name: stage_channel_sequencer

Overview:
Generalised channel launch/join controller for decoder stages with per-channel processing units such as reorder, stereo and antialias. It launches NUM_CH channel engines from one stage_ready pulse, either all in parallel or one after another when the engines share a memory port. It then joins their done pulses into a single stage_done. Additions over the existing two-channel done latch: a channel enable mask (mono frames), a sequential mode, a timeout watchdog, and completion/overrun status.

Parameters:
NUM_CH, 2, number of channel engines (1..8)
SEQUENTIAL, 0, 0 = launch all enabled channels together; 1 = launch in ascending index order, next after previous done
TIMEOUT_CYCLES, 4096, max cycles in RUN without an accepted done; 0 disables watchdog
TO_W, 16, width of watchdog counter (must hold TIMEOUT_CYCLES)

Ports:
clk  in  1  stage clock
rst  in  1  reset; asynchronous, active-low
stage_ready  in  1  one-cycle start pulse from the stage controller
channel_mask  in  NUM_CH  enabled channels; sampled only when stage_ready is accepted
channel_ready  out  NUM_CH  one-cycle launch pulse per channel
channel_done  in  NUM_CH  one-cycle completion pulse per channel
stage_done  out  1  one-cycle pulse: all enabled channels finished or watchdog fired
stage_busy  out  1  high in RUN
stage_timeout  out  1  one-cycle pulse coincident with stage_done when ended by watchdog
done_status  out  NUM_CH  channels completed in last run; valid from the stage_done cycle until the next accept
overrun  out  1  sticky: stage_ready seen while busy; cleared only by reset

Behaviour:
- Reset (rst low, async) applies these values:
  - Outputs: channel_ready=0, stage_done=0, stage_busy=0, stage_timeout=0, done_status=0, overrun=0.
  - Internal: state=IDLE, pending mask=0, launched mask=0, watchdog counter=0.
- Reset mid-run aborts the run silently. No stage_done is issued.
- All outputs are registered.
- States: IDLE, RUN.
- IDLE, stage_ready=1, channel_mask=0:
  - stage_done pulses at t+1 with done_status=0.
  - State stays IDLE.
- IDLE, stage_ready=1, channel_mask≠0 (accept at cycle t):
  - Latch pending=channel_mask, clear done_status, go RUN; stage_busy=1 from t+1.
  - Parallel mode: channel_ready=channel_mask at t+1.
  - Sequential mode: channel_ready=one-hot of the lowest set bit at t+1.
- RUN, done capture:
  - channel_done[i] is accepted only if channel i is launched and not yet done. Launched means its channel_ready pulse has already been issued, and the pulse cycle itself counts.
  - Any other done pulse is ignored: unmasked, not yet launched, or duplicate.
  - An accepted done sets done_status[i].
- RUN, sequential launch: the done of the current channel accepted at cycle d pulses channel_ready for the next higher set bit at d+1.
- RUN, completion: when done_status equals pending (last accept at cycle d):
  - stage_done=1 at d+1, stage_busy=0 at d+1, state returns to IDLE.
  - A new stage_ready is accepted from d+1 onward.
- Simultaneous done pulses (parallel mode) are all accepted in the same cycle.
- Watchdog:
  - The counter clears on accept and on every accepted done, and increments each other RUN cycle.
  - When it reaches TIMEOUT_CYCLES, stage_done and stage_timeout pulse together the next cycle and state returns to IDLE.
  - done_status then shows the partial completion set. Channels not yet launched are never launched.
  - Done and timeout in the same cycle: the done wins when it completes the set, and stage_timeout stays 0.
- stage_ready in RUN is ignored and sets overrun.
- stage_ready in the same cycle that stage_done is high (state already IDLE) is accepted normally.

Test Plan:
1. NUM_CH=2, parallel, mask=11, stage_ready@t0 → channel_ready=11@t1; done[0]@t5, done[1]@t9 → stage_done@t10 only, done_status=11, stage_busy low@t10.
2. Sequential NUM_CH=4, mask=1010 → channel_ready=0010@t1; done[1]@t6 → channel_ready=1000@t7; done[3]@t12 → stage_done@t13; channel 0 and channel 2 never pulsed.
3. Mask=0001 (mono), spurious done[1]@t3, done[0]@t4 → stage_done@t5, done_status=0001; mask=0000 → stage_done one cycle after stage_ready, no channel_ready.
4. TIMEOUT_CYCLES=16, mask=11, only done[0] @t3 → stage_done and stage_timeout pulse at t20, done_status=01; a later done[1] is ignored.
5. stage_ready re-asserted during RUN → overrun=1 and stays 1, run unaffected. Duplicate done[0] is ignored. Done[0] and done[1] in the same cycle complete the run.
6. rst low mid-RUN → all outputs 0 immediately (async). After release, state is IDLE and the next stage_ready starts a clean run.
